// File: rtl/hazard_unit.sv
// Pipeline hazard and bypass controller: scoreboard of in-flight writes driving
// bypass selects, load-use stalls, flow-change flushes and sticky halt.
module hazard_unit #(
    parameter int W           = 4,
    parameter int NUM_SRC     = 2,
    parameter int DEPTH       = 3,
    parameter int LOAD_LAT    = 1,
    parameter int FLUSH_DEPTH = 2,
    localparam int SW         = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic                  id_rf_we,
    input  logic [W-1:0]          id_dst,
    input  logic                  id_is_load,
    input  logic                  id_hlt,
    input  logic [NUM_SRC-1:0]    id_src_re,
    input  logic [NUM_SRC*W-1:0]  id_src_addr,
    input  logic                  ex_cond_kill,
    input  logic                  flow_change,
    output logic                  stall_id,
    output logic                  bubble,
    output logic [NUM_SRC*SW-1:0] byp_sel,
    output logic                  wb_we,
    output logic [W-1:0]          wb_dst,
    output logic                  hlt_wb
);
    localparam int FW = (FLUSH_DEPTH > 1) ? $clog2(FLUSH_DEPTH) : 1;
    localparam logic [FW-1:0] FLUSH_RELOAD = FW'(FLUSH_DEPTH - 1);

    logic [DEPTH:1]         ent_we_q, ent_we_d;
    logic [DEPTH:1]         ent_ld_q, ent_ld_d;
    logic [DEPTH:1]         ent_hlt_q, ent_hlt_d;
    logic [DEPTH:1][W-1:0]  ent_dst_q, ent_dst_d;
    logic [FW-1:0]          fcnt_q, fcnt_d;
    logic                   halted_q, halted_d;
    logic                   hlt_seen_q, hlt_seen_d;
    logic [NUM_SRC*SW-1:0]  byp_q, byp_d;

    logic [DEPTH:1]         eff_we;
    logic [NUM_SRC*SW-1:0]  win_all;
    logic [SW-1:0]          win;
    logic                   win_ld;
    logic [W-1:0]           src;
    logic                   load_use;
    logic                   squash;

    // Youngest producer wins: scan oldest to youngest so the last hit sticks.
    always_comb begin
        eff_we    = ent_we_q;
        eff_we[1] = ent_we_q[1] & ~ex_cond_kill;
        win_all   = '0;
        load_use  = 1'b0;
        win       = '0;
        win_ld    = 1'b0;
        src       = '0;
        for (int unsigned s = 0; s < NUM_SRC; s++) begin
            win    = '0;
            win_ld = 1'b0;
            src    = id_src_addr[s*W +: W];
            for (int unsigned d = DEPTH; d >= 1; d--) begin
                if (id_src_re[s] && (src != '0) && eff_we[d] && (ent_dst_q[d] == src)) begin
                    win    = SW'(d);
                    win_ld = ent_ld_q[d];
                end
            end
            win_all[s*SW +: SW] = win;
            if (win_ld && (win != '0) && (int'(win) <= LOAD_LAT)) begin
                load_use = 1'b1;
            end
        end
        squash   = flow_change | (fcnt_q != '0);
        stall_id = rst_n & (halted_q | (load_use & ~squash));
        bubble   = halted_q | squash | load_use | ~id_valid;
    end

    always_comb begin
        ent_we_d  = '0;
        ent_ld_d  = '0;
        ent_hlt_d = '0;
        ent_dst_d = '0;
        if (!bubble) begin
            ent_we_d[1]  = id_rf_we;
            ent_ld_d[1]  = id_is_load;
            ent_hlt_d[1] = id_hlt;
            ent_dst_d[1] = id_dst;
        end
        for (int unsigned k = 2; k <= DEPTH; k++) begin
            ent_we_d[k]  = ent_we_q[k-1];
            ent_ld_d[k]  = ent_ld_q[k-1];
            ent_hlt_d[k] = ent_hlt_q[k-1];
            ent_dst_d[k] = ent_dst_q[k-1];
        end
        ent_we_d[2] = eff_we[1];

        if (flow_change)         fcnt_d = FLUSH_RELOAD;
        else if (fcnt_q != '0)   fcnt_d = fcnt_q - 1'b1;
        else                     fcnt_d = '0;

        // Halt latches only once the HLT actually issues into stage 1.
        halted_d   = halted_q | (~bubble & id_hlt);
        hlt_seen_d = hlt_seen_q | ent_hlt_q[DEPTH];
        byp_d      = bubble ? '0 : win_all;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ent_we_q   <= '0;
            ent_ld_q   <= '0;
            ent_hlt_q  <= '0;
            ent_dst_q  <= '0;
            fcnt_q     <= '0;
            halted_q   <= 1'b0;
            hlt_seen_q <= 1'b0;
            byp_q      <= '0;
        end else begin
            ent_we_q   <= ent_we_d;
            ent_ld_q   <= ent_ld_d;
            ent_hlt_q  <= ent_hlt_d;
            ent_dst_q  <= ent_dst_d;
            fcnt_q     <= fcnt_d;
            halted_q   <= halted_d;
            hlt_seen_q <= hlt_seen_d;
            byp_q      <= byp_d;
        end
    end

    assign byp_sel = byp_q;
    assign wb_we   = ent_we_q[DEPTH];
    assign wb_dst  = ent_dst_q[DEPTH];
    assign hlt_wb  = hlt_seen_q | ent_hlt_q[DEPTH];
endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios plus random traffic
// compared against a time-history model of issued instructions.
module tb_hazard_unit;
    localparam int W = 4;
    localparam int NUM_SRC = 2;
    localparam int DEPTH = 3;
    localparam int LOAD_LAT = 1;
    localparam int FLUSH_DEPTH = 2;
    localparam int SW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic         we;
        logic [W-1:0] dst;
        logic         ld;
        logic         hlt;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n, id_valid, id_rf_we, id_is_load, id_hlt, ex_cond_kill, flow_change;
    logic [W-1:0] id_dst;
    logic [NUM_SRC-1:0] id_src_re;
    logic [NUM_SRC*W-1:0] id_src_addr;
    logic stall_id, bubble, wb_we, hlt_wb;
    logic [NUM_SRC*SW-1:0] byp_sel;
    logic [W-1:0] wb_dst;

    hazard_unit #(.W(W), .NUM_SRC(NUM_SRC), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT),
                  .FLUSH_DEPTH(FLUSH_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rf_we(id_rf_we),
        .id_dst(id_dst), .id_is_load(id_is_load), .id_hlt(id_hlt),
        .id_src_re(id_src_re), .id_src_addr(id_src_addr),
        .ex_cond_kill(ex_cond_kill), .flow_change(flow_change),
        .stall_id(stall_id), .bubble(bubble), .byp_sel(byp_sel),
        .wb_we(wb_we), .wb_dst(wb_dst), .hlt_wb(hlt_wb)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Model: hist[d-1] is whatever was issued into stage 1 d cycles ago.
    ent_t hist[$];
    int   fl_left = 0;
    logic m_halted = 1'b0;
    logic m_hltwb = 1'b0;
    logic [NUM_SRC*SW-1:0] m_byp = '0;
    logic armed = 1'b0;
    int   halt_cycles = 0;

    logic s_stall, s_bubble, s_wbwe, s_hltwb;
    logic [NUM_SRC*SW-1:0] s_byp;
    logic [W-1:0] s_wbdst;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic step();
        int   wins [NUM_SRC];
        logic lds  [NUM_SRC];
        logic lu, sq, e_stall, e_bubble, e_hltwb;
        logic [NUM_SRC*SW-1:0] nxt_byp;
        ent_t e, oldest;
        logic [W-1:0] a;
        @(negedge clk);
        lu = 1'b0;
        nxt_byp = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            wins[i] = 0;
            lds[i]  = 1'b0;
            a = id_src_addr[i*W +: W];
            for (int d = 1; d <= DEPTH; d++) begin
                e = hist[d-1];
                if (d == 1) e.we = e.we & ~ex_cond_kill;
                if (wins[i] == 0 && id_src_re[i] && a != 0 && e.we && e.dst == a) begin
                    wins[i] = d;
                    lds[i]  = e.ld;
                end
            end
            if (wins[i] != 0 && lds[i] && wins[i] <= LOAD_LAT) lu = 1'b1;
            nxt_byp[i*SW +: SW] = SW'(wins[i]);
        end
        sq       = flow_change || fl_left > 0;
        e_stall  = rst_n && (m_halted || (lu && !sq));
        e_bubble = m_halted || sq || lu || !id_valid;
        oldest   = hist[DEPTH-1];
        e_hltwb  = m_hltwb || oldest.hlt;

        s_stall = stall_id; s_bubble = bubble; s_byp = byp_sel;
        s_wbwe = wb_we; s_wbdst = wb_dst; s_hltwb = hlt_wb;
        if (armed) begin
            cmp("stall_id", 32'(stall_id), 32'(e_stall));
            cmp("bubble", 32'(bubble), 32'(e_bubble));
            cmp("byp_sel", 32'(byp_sel), 32'(m_byp));
            cmp("wb_we", 32'(wb_we), 32'(oldest.we));
            if (oldest.we) cmp("wb_dst", 32'(wb_dst), 32'(oldest.dst));
            cmp("hlt_wb", 32'(hlt_wb), 32'(e_hltwb));
        end

        @(posedge clk);
        #1;
        if (!rst_n) begin
            hist.delete();
            for (int d = 0; d < DEPTH; d++) hist.push_back('0);
            fl_left = 0; m_halted = 1'b0; m_hltwb = 1'b0; m_byp = '0;
            armed = 1'b1;
        end else begin
            hist[0].we = hist[0].we & ~ex_cond_kill;
            e = '0;
            if (!e_bubble) e = '{we: id_rf_we, dst: id_dst, ld: id_is_load, hlt: id_hlt};
            hist.push_front(e);
            void'(hist.pop_back());
            fl_left  = flow_change ? FLUSH_DEPTH - 1 : (fl_left > 0 ? fl_left - 1 : 0);
            m_halted = m_halted || (!e_bubble && id_hlt);
            m_hltwb  = e_hltwb;
            m_byp    = e_bubble ? '0 : nxt_byp;
        end
    endtask

    task automatic set_id(input logic v, input logic we, input logic [W-1:0] dst,
                          input logic ld, input logic hlt, input logic [1:0] re,
                          input logic [W-1:0] a0, input logic [W-1:0] a1);
        id_valid = v; id_rf_we = we; id_dst = dst; id_is_load = ld; id_hlt = hlt;
        id_src_re = re; id_src_addr = {a1, a0};
        ex_cond_kill = 1'b0; flow_change = 1'b0;
    endtask

    task automatic nop();
        set_id(1'b0, 1'b0, '0, 1'b0, 1'b0, 2'b00, '0, '0);
    endtask

    task automatic drain();
        nop();
        for (int i = 0; i < DEPTH + 1; i++) step();
    endtask

    initial begin
        for (int d = 0; d < DEPTH; d++) hist.push_back('0);
        rst_n = 1'b0;
        nop();
        step(); step();
        cmp("reset_stall", 32'(s_stall), 32'd0);
        cmp("reset_byp", 32'(s_byp), 32'd0);
        cmp("reset_wb_we", 32'(s_wbwe), 32'd0);
        cmp("reset_hlt_wb", 32'(s_hltwb), 32'd0);
        rst_n = 1'b1;

        // ADD R3, then a reader of R3 on both sources
        set_id(1, 1, 3, 0, 0, 2'b00, 0, 0); step();
        set_id(1, 0, 0, 0, 0, 2'b11, 3, 3); step();
        cmp("add_no_stall", 32'(s_stall), 32'd0);
        nop(); step();
        cmp("add_byp_11", 32'(s_byp), 32'h5);
        drain();

        // LW R5, then ADD reading R5 on source 1
        set_id(1, 1, 5, 1, 0, 2'b00, 0, 0); step();
        set_id(1, 1, 6, 0, 0, 2'b10, 0, 5); step();
        cmp("lu_stall", 32'(s_stall), 32'd1);
        cmp("lu_bubble", 32'(s_bubble), 32'd1);
        step();
        cmp("lu_release", 32'(s_stall), 32'd0);
        nop(); step();
        cmp("lu_byp_2", 32'(s_byp), 32'h8);
        drain();

        // flow_change in the same cycle as a load-use hazard
        set_id(1, 1, 5, 1, 0, 2'b00, 0, 0); step();
        set_id(1, 1, 6, 0, 0, 2'b10, 0, 5); flow_change = 1'b1; step();
        cmp("fl_bubble", 32'(s_bubble), 32'd1);
        cmp("fl_stall", 32'(s_stall), 32'd0);
        flow_change = 1'b0; step();
        cmp("fl2_bubble", 32'(s_bubble), 32'd1);
        cmp("fl2_stall", 32'(s_stall), 32'd0);
        step();
        cmp("fl_byp_0", 32'(s_byp), 32'd0);
        drain();

        // ADDZ R4 killed in stage 1, followed by a reader of R4
        set_id(1, 1, 4, 0, 0, 2'b00, 0, 0); step();
        set_id(1, 0, 0, 0, 0, 2'b01, 4, 0); ex_cond_kill = 1'b1; step();
        cmp("kill_no_stall", 32'(s_stall), 32'd0);
        nop(); step();
        cmp("kill_byp_0", 32'(s_byp), 32'd0);
        step();
        cmp("kill_wb_we", 32'(s_wbwe), 32'd0);
        cmp("kill_wb_dst", 32'(s_wbdst), 32'd4);
        drain();

        // HLT, then reset
        set_id(1, 0, 0, 0, 1, 2'b00, 0, 0); step();
        nop(); step();
        cmp("hlt_stall1", 32'(s_stall), 32'd1);
        step();
        cmp("hlt_wb_early", 32'(s_hltwb), 32'd0);
        step();
        cmp("hlt_wb_set", 32'(s_hltwb), 32'd1);
        cmp("hlt_stall3", 32'(s_stall), 32'd1);
        rst_n = 1'b0; step();
        rst_n = 1'b1; step();
        cmp("post_rst_stall", 32'(s_stall), 32'd0);
        cmp("post_rst_hlt_wb", 32'(s_hltwb), 32'd0);
        cmp("post_rst_byp", 32'(s_byp), 32'd0);

        // Random traffic on a small register set to provoke hazards
        for (int c = 0; c < 3000; c++) begin
            id_valid     = ($urandom_range(0, 9) != 0);
            id_rf_we     = ($urandom_range(0, 9) < 7);
            id_dst       = W'($urandom_range(0, 3));
            id_is_load   = ($urandom_range(0, 9) < 3);
            id_hlt       = ($urandom_range(0, 199) == 0);
            id_src_re    = NUM_SRC'($urandom_range(0, 3));
            id_src_addr  = {W'($urandom_range(0, 3)), W'($urandom_range(0, 3))};
            ex_cond_kill = ($urandom_range(0, 4) == 0);
            flow_change  = ($urandom_range(0, 9) == 0);
            halt_cycles  = m_halted ? halt_cycles + 1 : 0;
            rst_n = !(($urandom_range(0, 199) == 0) || halt_cycles > 8);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
